bus_cycle_ctrl: RTL and testbench
=================================

# bus_cycle_ctrl

Memory bus cycle controller sitting directly downstream of status_counter in the CPU control path. It watches the memory-access phase flags (IF1, FF1, TF1, IT1) and runs one request/ready handshake per phase against the memory port, with enforced minimum wait states and a timeout. It returns a one-cycle ACK to status_counter so the counter advances to the next phase, and registers read data on completion.

## Interface
- DW, 16, data bus width
- MIN_WAIT, 1, minimum REQ cycles before mem_ready is honoured (0..254)
- TIMEOUT, 15, REQ cycle count at which the access is forcibly ended (MIN_WAIT < TIMEOUT ≤ 255)

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  one clock; reset is synchronous and active-low
- IF1  in  1  instruction-fetch access phase from status_counter (read)
- FF1  in  1  operand fetch-from phase (read)
- TF1  in  1  operand store-to phase (write)
- IT1  in  1  interrupt save phase (write)
- mem_ready  in  1  memory completion, sampled only in REQ
- mem_rdata  in  DW  memory read data, valid with mem_ready
- ACK  out  1  one-cycle completion pulse to status_counter
- mem_req  out  1  memory request, held through REQ
- mem_we  out  1  1 = write access, valid while mem_req=1
- acc_type  out  2  latched access: 00 IF, 01 FF, 10 TF, 11 IT
- rdata  out  DW  registered read data
- busy  out  1  high in any state except IDLE
- timeout  out  1  last access ended by timeout
- multi_err  out  1  one-cycle pulse: >1 phase flag high when sampled in IDLE

## Operation
- States: IDLE, REQ, DONE, HOLD. Internal 8-bit wait_cnt.
- Reset (reset=0 at an edge, any state): state IDLE; ACK, mem_req, mem_we, busy, timeout, multi_err = 0; acc_type = 00; rdata = 0; wait_cnt = 0.
- IDLE: when any phase flag is 1, latch acc_type by priority IT1 > TF1 > FF1 > IF1; mem_we = 1 for TF/IT, 0 for IF/FF; wait_cnt = 0; timeout cleared; multi_err pulses if more than one flag is 1; go REQ.
- REQ: mem_req = 1. Per cycle, in priority order:
  - latched phase flag now 0 → abort: IDLE, no ACK, rdata unchanged.
  - mem_ready=1 and wait_cnt ≥ MIN_WAIT → DONE; for reads, rdata ← mem_rdata.
  - wait_cnt == TIMEOUT → DONE with timeout=1, rdata unchanged.
  - otherwise wait_cnt += 1.
- mem_ready while wait_cnt < MIN_WAIT is ignored; memory must hold it.
- DONE: ACK = 1, mem_req = 0; go HOLD.
- HOLD: stay until latched phase flag is 0, then IDLE. No new access is started from HOLD, even if a different flag is already high; that flag is sampled in the following IDLE cycle.
- wait_cnt saturates by construction (never exceeds TIMEOUT); no wrap.

## Timing
- Phase flag high at edge n (in IDLE) → mem_req high from cycle n+1.
- The first REQ cycle has wait_cnt=0. With mem_ready=1 continuously, DONE (ACK=1) occurs MIN_WAIT+1 cycles after mem_req rises. MIN_WAIT=0 gives ACK 2 cycles after the phase is sampled.
- Timeout: ACK occurs TIMEOUT+1 cycles after mem_req rises. If mem_ready and the timeout condition occur in the same cycle, mem_ready wins and timeout=0.
- rdata updates on the same edge that enters DONE and is stable while ACK=1.
- ACK is exactly one cycle wide; status_counter advances on that edge, so the phase flag normally drops one cycle later and HOLD lasts 1 cycle.
- Back-to-back accesses are at least 4 cycles apart (IDLE, REQ, DONE, HOLD).
- Reset low mid-REQ drops mem_req on the next edge; no ACK is issued.

## Test plan
- Reset: reset=0 for 2 cycles during REQ, then 1 → all outputs 0, rdata=0, state IDLE, no ACK.
- Read, MIN_WAIT=1: IF1=1, mem_ready=1 always, mem_rdata=16'hA5C3 → mem_req high 2 cycles, mem_we=0, acc_type=00, ACK at cycle 3, rdata=A5C3, timeout=0.
- Write with late ready: TF1=1, mem_ready rises in the 5th REQ cycle → mem_we=1, acc_type=10, ACK the following cycle, rdata unchanged.
- Timeout, TIMEOUT=15: FF1=1, mem_ready=0 → ACK 16 cycles after mem_req rises, timeout=1 until next access. Repeat with mem_ready=1 in the 16th REQ cycle → timeout=0, rdata loaded.
- Priority/multi: IT1=1 and IF1=1 together → acc_type=11, mem_we=1, multi_err 1-cycle pulse.
- Abort and hold: drop FF1 mid-REQ → mem_req=0 next cycle, no ACK. Keep IF1 high after ACK → stays HOLD, no second mem_req until IF1 goes low and high again.

Source files
------------

// File: rtl/bus_cycle_ctrl.sv
// Memory bus cycle controller: runs one request/ready handshake per memory-access
// phase flag, with a minimum wait, a timeout, and a one-cycle ACK back to status_counter.
//
// state | meaning
// IDLE  | waiting for a phase flag; latches access type on the first flag seen
// REQ   | mem_req asserted; counting wait states until ready, timeout or abort
// DONE  | one-cycle ACK to status_counter
// HOLD  | waiting for the latched phase flag to drop before a new access
module bus_cycle_ctrl #(
  parameter int DW       = 16,
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          IF1,
  input  logic          FF1,
  input  logic          TF1,
  input  logic          IT1,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          ACK,
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    acc_type,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          timeout,
  output logic          multi_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [7:0] MIN_WAIT_C = 8'(MIN_WAIT);
  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic       any_flag;
  logic       multi_flag;
  logic [1:0] sel_type;
  logic       flag_sel;
  logic [2:0] flag_cnt;

  assign any_flag   = IF1 | FF1 | TF1 | IT1;
  assign flag_cnt   = {2'b00, IF1} + {2'b00, FF1} + {2'b00, TF1} + {2'b00, IT1};
  assign multi_flag = (flag_cnt > 3'd1);

  // Highest-priority flag wins when several phases are raised together.
  always_comb begin
    sel_type = 2'b00;
    if (IT1)      sel_type = 2'b11;
    else if (TF1) sel_type = 2'b10;
    else if (FF1) sel_type = 2'b01;
    else          sel_type = 2'b00;
  end

  // Only the latched phase can keep an access alive or release HOLD.
  always_comb begin
    flag_sel = 1'b0;
    case (acc_type)
      2'b00:   flag_sel = IF1;
      2'b01:   flag_sel = FF1;
      2'b10:   flag_sel = TF1;
      default: flag_sel = IT1;
    endcase
  end

  assign mem_req = (state == ST_REQ);
  assign ACK     = (state == ST_DONE);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 8'd0;
      mem_we    <= 1'b0;
      acc_type  <= 2'b00;
      rdata     <= '0;
      timeout   <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      multi_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_flag) begin
            acc_type  <= sel_type;
            mem_we    <= sel_type[1];
            wait_cnt  <= 8'd0;
            timeout   <= 1'b0;
            multi_err <= multi_flag;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!flag_sel) begin
            state <= ST_IDLE;
          end else if (mem_ready && (wait_cnt >= MIN_WAIT_C)) begin
            if (!mem_we) rdata <= mem_rdata;
            state <= ST_DONE;
          end else if (wait_cnt == TIMEOUT_C) begin
            timeout <= 1'b1;
            state   <= ST_DONE;
          end else begin
            // Cannot pass TIMEOUT: the compare above ends the access first.
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_HOLD;
        ST_HOLD: begin
          if (!flag_sel) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: expected completions are queued when an access
// is launched and checked against the DUT whenever ACK is seen.
module tb_bus_cycle_ctrl;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          IF1, FF1, TF1, IT1;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          ACK, mem_req, mem_we, busy, timeout, multi_err;
  logic [1:0]    acc_type;
  logic [DW-1:0] rdata;

  typedef struct {
    logic [1:0]    at;
    logic          we;
    logic [DW-1:0] rd;
    logic          to;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  bus_cycle_ctrl #(.DW(DW), .MIN_WAIT(1), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .IF1       (IF1),
    .FF1       (FF1),
    .TF1       (TF1),
    .IT1       (IT1),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .ACK       (ACK),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .acc_type  (acc_type),
    .rdata     (rdata),
    .busy      (busy),
    .timeout   (timeout),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] at, input logic we, input logic [DW-1:0] rd,
                      input logic to);
    exp_t e;
    e.at = at; e.we = we; e.rd = rd; e.to = to;
    sbq.push_back(e);
  endtask

  // Scoreboard side: every ACK must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && ACK === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 32'(ACK), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_acc_type", 32'(acc_type), 32'(e.at));
        chk("sb_mem_we",   32'(mem_we),   32'(e.we));
        chk("sb_rdata",    32'(rdata),    32'(e.rd));
        chk("sb_timeout",  32'(timeout),  32'(e.to));
      end
    end
  end

  initial begin
    int cnt;
    reset = 1'b0; IF1 = 0; FF1 = 0; TF1 = 0; IT1 = 0;
    mem_ready = 0; mem_rdata = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_ack", 32'(ACK), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_type", 32'(acc_type), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_multi", 32'(multi_err), 0);

    // Reset asserted in the middle of REQ
    IF1 = 1; mem_rdata = 16'hBEEF;
    tick();
    chk("midrst_req_up", 32'(mem_req), 1);
    reset = 1'b0;
    tick();
    chk("midrst_req_drop", 32'(mem_req), 0);
    chk("midrst_ack0", 32'(ACK), 0);
    tick();
    chk("midrst_busy", 32'(busy), 0);
    IF1 = 0; reset = 1'b1;
    tick();
    chk("midrst_rdata", 32'(rdata), 0);
    chk("midrst_busy2", 32'(busy), 0);
    chk("midrst_ack1", 32'(ACK), 0);

    // Read, ready held high
    mem_ready = 1; mem_rdata = 16'hA5C3; IF1 = 1;
    push(2'b00, 1'b0, 16'hA5C3, 1'b0);
    tick();
    chk("rd_req_c1", 32'(mem_req), 1);
    chk("rd_we", 32'(mem_we), 0);
    chk("rd_type", 32'(acc_type), 0);
    chk("rd_multi", 32'(multi_err), 0);
    chk("rd_ack_c1", 32'(ACK), 0);
    tick();
    chk("rd_req_c2", 32'(mem_req), 1);
    chk("rd_ack_c2", 32'(ACK), 0);
    tick();
    chk("rd_ack", 32'(ACK), 1);
    chk("rd_req_done", 32'(mem_req), 0);
    chk("rd_rdata", 32'(rdata), 32'h0000A5C3);
    IF1 = 0;
    tick();
    chk("rd_ack_width", 32'(ACK), 0);
    chk("rd_hold_busy", 32'(busy), 1);
    tick();
    chk("rd_idle", 32'(busy), 0);

    // Write, ready in 5th REQ cycle
    mem_ready = 0; mem_rdata = 16'h1234; TF1 = 1;
    push(2'b10, 1'b1, 16'hA5C3, 1'b0);
    tick();
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_type", 32'(acc_type), 2);
    repeat (4) tick();
    mem_ready = 1;
    chk("wr_ack_c5", 32'(ACK), 0);
    chk("wr_req_c5", 32'(mem_req), 1);
    tick();
    chk("wr_ack", 32'(ACK), 1);
    chk("wr_rdata", 32'(rdata), 32'h0000A5C3);
    TF1 = 0; mem_ready = 0;
    repeat (2) tick();

    // Timeout
    FF1 = 1;
    push(2'b01, 1'b0, 16'hA5C3, 1'b1);
    tick();
    chk("to_req_up", 32'(mem_req), 1);
    cnt = 0;
    while (ACK !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("to_latency", 32'(cnt), 16);
    chk("to_flag", 32'(timeout), 1);
    FF1 = 0;
    repeat (2) tick();
    chk("to_flag_idle", 32'(timeout), 1);

    // Ready arrives in the last REQ cycle: ready wins
    FF1 = 1; mem_rdata = 16'h5A5A;
    push(2'b01, 1'b0, 16'h5A5A, 1'b0);
    tick();
    chk("to2_clear", 32'(timeout), 0);
    repeat (15) tick();
    chk("to2_ack_c16", 32'(ACK), 0);
    mem_ready = 1;
    tick();
    chk("to2_ack", 32'(ACK), 1);
    chk("to2_flag", 32'(timeout), 0);
    chk("to2_rdata", 32'(rdata), 32'h00005A5A);
    FF1 = 0; mem_ready = 0;
    repeat (2) tick();

    // Priority and multi-flag
    IT1 = 1; IF1 = 1; mem_ready = 1; mem_rdata = 16'hFF00;
    push(2'b11, 1'b1, 16'h5A5A, 1'b0);
    tick();
    chk("pri_multi", 32'(multi_err), 1);
    chk("pri_type", 32'(acc_type), 3);
    chk("pri_we", 32'(mem_we), 1);
    tick();
    chk("pri_multi_pulse", 32'(multi_err), 0);
    tick();
    chk("pri_ack", 32'(ACK), 1);
    IT1 = 0; IF1 = 0;
    repeat (2) tick();

    // Abort mid-REQ
    FF1 = 1; mem_ready = 0;
    repeat (2) tick();
    chk("ab_req", 32'(mem_req), 1);
    FF1 = 0;
    tick();
    chk("ab_req_drop", 32'(mem_req), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_ack", 32'(ACK), 0);
    tick();
    chk("ab_ack2", 32'(ACK), 0);
    chk("ab_rdata", 32'(rdata), 32'h00005A5A);

    // Hold with flag kept high
    IF1 = 1; mem_ready = 1; mem_rdata = 16'h1111;
    push(2'b00, 1'b0, 16'h1111, 1'b0);
    repeat (3) tick();
    chk("hd_ack", 32'(ACK), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hd_no_req", 32'(mem_req), 0);
      chk("hd_busy", 32'(busy), 1);
    end
    TF1 = 1;
    push(2'b10, 1'b1, 16'h1111, 1'b0);
    tick();
    chk("hd_other_flag", 32'(mem_req), 0);
    IF1 = 0;
    tick();
    chk("hd_idle", 32'(busy), 0);
    chk("hd_idle_req", 32'(mem_req), 0);
    tick();
    chk("hd_next_req", 32'(mem_req), 1);
    chk("hd_next_type", 32'(acc_type), 2);
    chk("hd_next_multi", 32'(multi_err), 0);
    repeat (2) tick();
    chk("hd_next_ack", 32'(ACK), 1);
    TF1 = 0; mem_ready = 0;
    repeat (3) tick();

    chk("sb_drained", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
